// File: rtl/ssc_pkg.sv
// Shared types and helpers for the sequential snack shopping calculator.
package ssc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_SORT  = 3'd2,
        ST_BUY   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Bit positions inside the mode input.
    localparam int MODE_ASC  = 0;
    localparam int MODE_SKIP = 1;

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Index width that can address n entries, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ssc_luhn.sv
// Combinational Luhn check over a BCD card number; any non-decimal nibble fails.
module ssc_luhn #(
    parameter int CARD_DIGITS = 16
) (
    input  logic [4*CARD_DIGITS-1:0] card_num,
    output logic                     ok
);

    localparam int SUM_W = $clog2(9*CARD_DIGITS + 1);

    logic [SUM_W-1:0] sum;
    logic             bad;
    logic [3:0]       digit;
    logic [4:0]       dbl;

    always_comb begin
        sum   = '0;
        bad   = 1'b0;
        digit = '0;
        dbl   = '0;
        for (int d = 0; d < CARD_DIGITS; d++) begin
            digit = card_num[d*4 +: 4];
            if (digit > 4'd9) begin
                bad = 1'b1;
            end
            // Odd positions counted from the rightmost digit are doubled.
            if ((d % 2) == 1) begin
                dbl = {digit, 1'b0};
                if (dbl > 5'd9) begin
                    dbl = dbl - 5'd9;
                end
            end else begin
                dbl = {1'b0, digit};
            end
            sum = sum + SUM_W'(dbl);
        end
        ok = !bad && ((sum % SUM_W'(10)) == '0);
    end

endmodule

// File: rtl/ssc_seq_calc.sv
// Sequential snack shopping calculator: Luhn card check, odd-even transposition
// sort of item totals, then a fixed-length greedy buy pass with valid/ready I/O.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for in_valid; in_ready high
// ST_CHECK | Luhn check on captured card; load totals or fail to DONE
// ST_SORT  | one odd-even transposition pass per cycle, N_ITEM passes
// ST_BUY   | one sorted item per cycle, N_ITEM cycles regardless of stop
// ST_DONE  | result presented; leaves on out_ready
module ssc_seq_calc
    import ssc_pkg::*;
#(
    parameter int N_ITEM      = 8,
    parameter int NUM_W       = 4,
    parameter int PRICE_W     = 4,
    parameter int MONEY_W     = 9,
    parameter int CARD_DIGITS = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [4*CARD_DIGITS-1:0]     card_num,
    input  logic [MONEY_W-1:0]           input_money,
    input  logic [N_ITEM*NUM_W-1:0]      snack_num,
    input  logic [N_ITEM*PRICE_W-1:0]    price,
    input  logic [1:0]                   mode,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_card_ok,
    output logic [MONEY_W-1:0]           out_change,
    output logic [$clog2(N_ITEM+1)-1:0]  out_count
);

    localparam int TOT_W = NUM_W + PRICE_W;
    localparam int CNT_W = $clog2(N_ITEM + 1);
    localparam int IDX_W = idx_w(N_ITEM);
    localparam int CMP_W = max_w(TOT_W, MONEY_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ITEM - 1);

    state_t state, state_nxt;

    logic [4*CARD_DIGITS-1:0]  card_q;
    logic [MONEY_W-1:0]        money_q;
    logic [N_ITEM*NUM_W-1:0]   snack_q;
    logic [N_ITEM*PRICE_W-1:0] price_q;
    logic [1:0]                mode_q;

    logic [TOT_W-1:0] total  [N_ITEM];
    logic [TOT_W-1:0] sorted [N_ITEM];
    logic [IDX_W-1:0] pass_cnt;
    logic [IDX_W-1:0] buy_idx;
    logic             stopped;
    logic [CNT_W-1:0] count_q;

    logic             luhn_ok;
    logic             swap;
    logic [TOT_W-1:0] cur_total;
    logic             afford;
    logic [MONEY_W-1:0] money_nxt;
    logic [CNT_W-1:0]   count_nxt;
    logic               stop_nxt;

    ssc_luhn #(
        .CARD_DIGITS(CARD_DIGITS)
    ) u_luhn (
        .card_num(card_q),
        .ok      (luhn_ok)
    );

    assign in_ready  = (state == ST_IDLE) && rst_n;
    assign out_valid = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (in_valid)              state_nxt = ST_CHECK;
            ST_CHECK: state_nxt = luhn_ok ? ST_SORT : ST_DONE;
            ST_SORT:  if (pass_cnt == LAST_IDX)  state_nxt = ST_BUY;
            ST_BUY:   if (buy_idx == LAST_IDX)   state_nxt = ST_DONE;
            ST_DONE:  if (out_ready)             state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Pairs within one pass are disjoint, so every swap reads the pre-pass array.
    always_comb begin
        swap = 1'b0;
        for (int i = 0; i < N_ITEM; i++) begin
            sorted[i] = total[i];
        end
        for (int j = 0; j < N_ITEM - 1; j++) begin
            if (1'(j) == pass_cnt[0]) begin
                swap = mode_q[MODE_ASC] ? (total[j] > total[j+1])
                                        : (total[j] < total[j+1]);
                if (swap) begin
                    sorted[j]   = total[j+1];
                    sorted[j+1] = total[j];
                end
            end
        end
    end

    always_comb begin
        cur_total = total[buy_idx];
        afford    = CMP_W'(money_q) >= CMP_W'(cur_total);
        money_nxt = money_q;
        count_nxt = count_q;
        stop_nxt  = stopped;
        if (!stopped) begin
            if (afford) begin
                money_nxt = MONEY_W'(CMP_W'(money_q) - CMP_W'(cur_total));
                if (cur_total != '0) begin
                    count_nxt = count_q + CNT_W'(1);
                end
            end else if (!mode_q[MODE_SKIP]) begin
                stop_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            card_q      <= '0;
            money_q     <= '0;
            snack_q     <= '0;
            price_q     <= '0;
            mode_q      <= '0;
            pass_cnt    <= '0;
            buy_idx     <= '0;
            stopped     <= 1'b0;
            count_q     <= '0;
            out_card_ok <= 1'b0;
            out_change  <= '0;
            out_count   <= '0;
            for (int i = 0; i < N_ITEM; i++) begin
                total[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        card_q  <= card_num;
                        money_q <= input_money;
                        snack_q <= snack_num;
                        price_q <= price;
                        mode_q  <= mode;
                    end
                end
                ST_CHECK: begin
                    if (luhn_ok) begin
                        for (int i = 0; i < N_ITEM; i++) begin
                            total[i] <= TOT_W'(snack_q[i*NUM_W +: NUM_W])
                                      * TOT_W'(price_q[i*PRICE_W +: PRICE_W]);
                        end
                        pass_cnt <= '0;
                        buy_idx  <= '0;
                        stopped  <= 1'b0;
                        count_q  <= '0;
                    end else begin
                        out_card_ok <= 1'b0;
                        out_change  <= money_q;
                        out_count   <= '0;
                    end
                end
                ST_SORT: begin
                    for (int i = 0; i < N_ITEM; i++) begin
                        total[i] <= sorted[i];
                    end
                    pass_cnt <= pass_cnt + IDX_W'(1);
                end
                ST_BUY: begin
                    money_q <= money_nxt;
                    count_q <= count_nxt;
                    stopped <= stop_nxt;
                    buy_idx <= buy_idx + IDX_W'(1);
                    if (buy_idx == LAST_IDX) begin
                        out_card_ok <= 1'b1;
                        out_change  <= money_nxt;
                        out_count   <= count_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ssc_seq_calc.sv
// Directed bench for ssc_seq_calc with hand-computed expected results.
module tb_ssc_seq_calc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] card_num;
    logic [8:0]  input_money;
    logic [31:0] snack_num;
    logic [31:0] price;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic        out_card_ok;
    logic [8:0]  out_change;
    logic [3:0]  out_count;

    int checks   = 0;
    int failures = 0;
    int lat;
    bit seen;

    localparam logic [63:0] CARD_OK  = 64'h4111_1111_1111_1111;
    localparam logic [63:0] CARD_BAD = 64'h4111_1111_1111_1112;
    localparam logic [63:0] CARD_HEX = 64'h4111_1111_1111_111A;

    ssc_seq_calc dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .card_num   (card_num),
        .input_money(input_money),
        .snack_num  (snack_num),
        .price      (price),
        .mode       (mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_card_ok(out_card_ok),
        .out_change (out_change),
        .out_count  (out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_req(input logic [63:0] c, input logic [8:0] m,
                           input logic [31:0] s, input logic [31:0] p,
                           input logic [1:0] md, input bit noise, output int latency);
        int waited = 0;
        while (!in_ready && waited < 40) begin
            tick();
            waited++;
        end
        chk("in_ready_before_req", in_ready, 1);
        card_num    = c;
        input_money = m;
        snack_num   = s;
        price       = p;
        mode        = md;
        in_valid    = 1'b1;
        tick();
        in_valid = 1'b0;
        latency  = 0;
        while (!out_valid && latency < 40) begin
            if (noise) begin
                in_valid    = 1'($urandom_range(0, 1));
                card_num    = {$urandom, $urandom};
                input_money = 9'($urandom);
                mode        = 2'($urandom);
            end
            tick();
            latency++;
        end
        in_valid = 1'b0;
        chk("out_valid_within_budget", out_valid, 1);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_out_valid_drop"}, out_valid, 0);
        chk({tag, "_in_ready_back"}, in_ready, 1);
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        card_num    = '0;
        input_money = '0;
        snack_num   = '0;
        price       = '0;
        mode        = '0;

        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_card_ok", out_card_ok, 0);
        chk("rst_change", out_change, 0);
        chk("rst_count", out_count, 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // Luhn failure: one-cycle latency, money returned untouched.
        run_req(CARD_BAD, 9'd100, 32'h1111_1111, 32'h1234_5678, 2'd0, 1'b0, lat);
        chk("bad_latency", lat, 1);
        chk("bad_card_ok", out_card_ok, 0);
        chk("bad_change", out_change, 100);
        chk("bad_count", out_count, 0);
        consume("bad");

        // Totals 8..1 sum to 36, all affordable.
        run_req(CARD_OK, 9'd200, 32'h1111_1111, 32'h1234_5678, 2'd0, 1'b0, lat);
        chk("full_latency", lat, 17);
        chk("full_card_ok", out_card_ok, 1);
        chk("full_change", out_change, 164);
        chk("full_count", out_count, 8);
        consume("full");

        // Totals {2,5,8,0...}, money 10 under each policy.
        run_req(CARD_OK, 9'd10, 32'h0000_0111, 32'h0000_0852, 2'd0, 1'b0, lat);
        chk("desc_stop_change", out_change, 2);
        chk("desc_stop_count", out_count, 1);
        consume("desc_stop");

        run_req(CARD_OK, 9'd10, 32'h0000_0111, 32'h0000_0852, 2'd2, 1'b0, lat);
        chk("desc_skip_change", out_change, 0);
        chk("desc_skip_count", out_count, 2);
        consume("desc_skip");

        run_req(CARD_OK, 9'd10, 32'h0000_0111, 32'h0000_0852, 2'd1, 1'b0, lat);
        chk("asc_stop_change", out_change, 3);
        chk("asc_stop_count", out_count, 2);
        chk("asc_stop_latency", lat, 17);
        consume("asc_stop");

        // Maximum totals 225 each: two fit in 511.
        run_req(CARD_OK, 9'd511, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0, 1'b0, lat);
        chk("max_change", out_change, 61);
        chk("max_count", out_count, 2);
        chk("max_card_ok", out_card_ok, 1);
        consume("max");

        run_req(CARD_HEX, 9'd511, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0, 1'b0, lat);
        chk("hex_card_ok", out_card_ok, 0);
        chk("hex_change", out_change, 511);
        chk("hex_count", out_count, 0);
        consume("hex");

        // Busy-time in_valid noise and back-pressure in DONE.
        run_req(CARD_OK, 9'd10, 32'h0000_0111, 32'h0000_0852, 2'd0, 1'b1, lat);
        chk("noise_latency", lat, 17);
        for (int k = 0; k < 5; k++) begin
            chk("hold_out_valid", out_valid, 1);
            chk("hold_change", out_change, 2);
            chk("hold_count", out_count, 1);
            chk("hold_in_ready", in_ready, 0);
            tick();
        end
        chk("hold_card_ok", out_card_ok, 1);
        consume("hold");

        // Reset pulse during SORT aborts the request.
        card_num    = CARD_OK;
        input_money = 9'd200;
        snack_num   = 32'h1111_1111;
        price       = 32'h1234_5678;
        mode        = 2'd0;
        in_valid    = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("sort_busy_in_ready", in_ready, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        seen = 1'b0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_result", seen, 0);

        run_req(CARD_OK, 9'd200, 32'h1111_1111, 32'h1234_5678, 2'd0, 1'b0, lat);
        chk("after_abort_latency", lat, 17);
        chk("after_abort_change", out_change, 164);
        chk("after_abort_count", out_count, 8);
        consume("after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
